// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: issues sequential word reads on the instruction bus
// and buffers {pc, word} pairs in a small FIFO for the decode stage.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   bus_bstart, bus_addr     transfer request / word address (held until bus_bdone)
//   bus_bdone, bus_rdata     completion pulse / returned word
//   inst_valid, inst, inst_pc, inst_ready   head entry handshake to decode
//   redirect, redirect_pc    flush and restart fetch at a new PC
//   stop_fetch               inhibit new requests (debug halt)
//   busy                     a bus transfer is outstanding
module ifetch_queue #(
  parameter logic [31:0] INITIAL_PC = 32'h0000_0000,
  parameter int          DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        bus_bstart,
  output logic [31:0] bus_addr,
  input  logic        bus_bdone,
  input  logic [31:0] bus_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stop_fetch,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } state_t;

  state_t          state;
  logic [31:0]     fetch_pc;
  logic [31:0]     hold_addr;
  logic [31:0]     q_inst [DEPTH];
  logic [31:0]     q_pc   [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic            push;
  logic            pop;
  logic            go;
  logic [31:0]     target;

  assign target     = {redirect_pc[31:2], 2'b00};
  assign inst_valid = (count != '0);
  assign push       = (state == REQ) && bus_bdone && !redirect;
  assign pop        = inst_valid && inst_ready && !redirect;

  // Occupancy after this cycle's events; a redirect empties the queue.
  always_comb begin
    count_next = count;
    if (redirect)
      count_next = '0;
    else
      count_next = count + CW'(push) - CW'(pop);
  end

  // A new request may start only if its data is guaranteed a free slot.
  assign go = !stop_fetch && (count_next < CW'(DEPTH));

  assign bus_bstart = (state != IDLE);
  assign busy       = bus_bstart;
  // While discarding, the abandoned transfer keeps its original address.
  assign bus_addr   = (state == DISCARD) ? hold_addr : fetch_pc;
  assign inst       = inst_valid ? q_inst[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? q_pc[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[wr_ptr] <= bus_rdata;
      q_pc[wr_ptr]   <= fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fetch_pc  <= INITIAL_PC;
      hold_addr <= INITIAL_PC;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      count <= count_next;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (redirect)
            fetch_pc <= target;
          else if (go)
            state <= REQ;
        end
        REQ: begin
          if (redirect) begin
            fetch_pc <= target;
            if (bus_bdone) begin
              state <= go ? REQ : IDLE;
            end else begin
              hold_addr <= fetch_pc;
              state     <= DISCARD;
            end
          end else if (bus_bdone) begin
            fetch_pc <= fetch_pc + 32'd4;
            state    <= go ? REQ : IDLE;
          end
        end
        DISCARD: begin
          if (redirect)
            fetch_pc <= target;
          if (bus_bdone)
            state <= go ? REQ : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: cycle table for streaming/backpressure,
// hand sequences for redirect, stop_fetch, reset mid-transfer and PC wrap.
module tb_ifetch_queue;

  logic        clk;
  logic        rst;
  logic        bus_bstart;
  logic [31:0] bus_addr;
  logic        bus_bdone;
  logic [31:0] bus_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stop_fetch;
  logic        busy;

  int checks = 0;
  int errors = 0;

  ifetch_queue #(
    .INITIAL_PC(32'h0000_0100),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus_bstart(bus_bstart),
    .bus_addr(bus_addr),
    .bus_bdone(bus_bdone),
    .bus_rdata(bus_rdata),
    .inst_valid(inst_valid),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_ready(inst_ready),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .stop_fetch(stop_fetch),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        bd;
    logic [31:0] rd;
    logic        rdy;
    logic        bs;
    logic [31:0] addr;
    logic        v;
    logic [31:0] ins;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic bs,
                     input logic [31:0] addr, input logic v,
                     input logic [31:0] ins, input logic [31:0] pc);
    checks++;
    if (bus_bstart !== bs || busy !== bs || bus_addr !== addr ||
        inst_valid !== v || inst !== ins || inst_pc !== pc) begin
      errors++;
      $display("FAIL %s: got bs=%b busy=%b addr=%h v=%b inst=%h pc=%h, want bs=%b addr=%h v=%b inst=%h pc=%h",
               name, bus_bstart, busy, bus_addr, inst_valid, inst, inst_pc,
               bs, addr, v, ins, pc);
    end
  endtask

  task automatic drive(input logic r, input logic bd, input logic [31:0] rd,
                       input logic rdy, input logic redir,
                       input logic [31:0] rpc, input logic stp);
    rst         = r;
    bus_bdone   = bd;
    bus_rdata   = rd;
    inst_ready  = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    stop_fetch  = stp;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h100, 1'b0, 32'h0,        32'h0};
    tbl[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h100, 1'b0, 32'h0,        32'h0};
    tbl[2]  = '{1'b1, 32'hA000_0000, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0,        32'h0};
    tbl[3]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h104, 1'b1, 32'hA000_0000, 32'h100};
    tbl[4]  = '{1'b1, 32'hA000_0001, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0,        32'h0};
    tbl[5]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h108, 1'b1, 32'hA000_0001, 32'h104};
    tbl[6]  = '{1'b1, 32'hA000_0002, 1'b1, 1'b1, 32'h108, 1'b0, 32'h0,        32'h0};
    tbl[7]  = '{1'b1, 32'hA000_0003, 1'b0, 1'b1, 32'h10C, 1'b1, 32'hA000_0002, 32'h108};
    tbl[8]  = '{1'b1, 32'hA000_0004, 1'b0, 1'b1, 32'h110, 1'b1, 32'hA000_0002, 32'h108};
    tbl[9]  = '{1'b1, 32'hA000_0005, 1'b0, 1'b1, 32'h114, 1'b1, 32'hA000_0002, 32'h108};
    tbl[10] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h118, 1'b1, 32'hA000_0002, 32'h108};
    tbl[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h118, 1'b1, 32'hA000_0002, 32'h108};
    tbl[12] = '{1'b1, 32'hA000_0006, 1'b0, 1'b1, 32'h118, 1'b1, 32'hA000_0003, 32'h10C};
    tbl[13] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h11C, 1'b1, 32'hA000_0003, 32'h10C};

    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("reset", 1'b0, 32'h100, 1'b0, 32'h0, 32'h0);

    for (int i = 0; i < 14; i++) begin
      chk($sformatf("table[%0d]", i), tbl[i].bs, tbl[i].addr,
          tbl[i].v, tbl[i].ins, tbl[i].pc);
      drive(1'b0, tbl[i].bd, tbl[i].rd, tbl[i].rdy, 1'b0, 32'h0, 1'b0);
    end

    // Redirect while idle and full, then redirect with a request pending.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_2002, 1'b0);
    chk("redir_idle", 1'b0, 32'h2000, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("req_2000", 1'b1, 32'h2000, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_3006, 1'b0);
    chk("discard_hold1", 1'b1, 32'h2000, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("discard_hold2", 1'b1, 32'h2000, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("discard_drop", 1'b1, 32'h3004, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b1, 32'hB000_0000, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("after_redir", 1'b1, 32'h3008, 1'b1, 32'hB000_0000, 32'h3004);

    // Redirect coincident with bdone and pop.
    drive(1'b0, 1'b1, 32'hDEAD_0001, 1'b1, 1'b1, 32'h0000_4000, 1'b0);
    chk("redir_bdone_pop", 1'b1, 32'h4000, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b1, 32'hC000_0000, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("push_4000", 1'b1, 32'h4004, 1'b1, 32'hC000_0000, 32'h4000);

    // stop_fetch mid-transfer.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("stop_pending", 1'b1, 32'h4004, 1'b1, 32'hC000_0000, 32'h4000);
    drive(1'b0, 1'b1, 32'hC000_0001, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("stop_done", 1'b0, 32'h4008, 1'b1, 32'hC000_0000, 32'h4000);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("stop_pop", 1'b0, 32'h4008, 1'b1, 32'hC000_0001, 32'h4004);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("stop_release", 1'b1, 32'h4008, 1'b1, 32'hC000_0001, 32'h4004);

    // Reset mid-transfer, late bdone ignored.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("reset_mid", 1'b0, 32'h100, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b1, 32'hDEAD_0002, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("late_bdone", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b1, 32'hD000_0000, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("restart_push", 1'b1, 32'h104, 1'b1, 32'hD000_0000, 32'h100);

    // Redirect with unaligned PC near the top, then fetch_pc wrap.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    chk("wrap_discard", 1'b1, 32'h104, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b1, 32'hDEAD_0003, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrap_req", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b1, 32'hE000_0000, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrap_zero", 1'b1, 32'h0, 1'b1, 32'hE000_0000, 32'hFFFF_FFFC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
